// File: rtl/nx_stream_fifo_pkg.sv
// nx_stream_fifo_pkg: shared helpers for the stream FIFO.
//   is_pow2      - true when the argument is a non-zero power of two
//   afull_legal  - true when an almost-full threshold fits the given depth
package nx_stream_fifo_pkg;

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit afull_legal(input int unsigned level, input int unsigned depth);
        return (level >= 1) && (level <= depth);
    endfunction

endpackage

// File: rtl/nx_stream_fifo.sv
// nx_stream_fifo: first-word fall-through stream FIFO with valid/ready handshakes.
//   clk_i, rst_i          - clock and asynchronous active-high reset
//   flush_i               - synchronous discard of all stored entries
//   inbound_*             - producer side (data/valid in, ready out)
//   outbound_*            - consumer side (data/valid out, ready in)
//   level_o               - current occupancy
//   empty_o/full_o        - occupancy equals 0 / DEPTH
//   almost_full_o         - occupancy at or above AFULL_LEVEL
// Status outputs come only from the registered pointers, so there is no
// combinational path between the two handshake sides.
module nx_stream_fifo
    import nx_stream_fifo_pkg::*;
#(
    parameter int unsigned STREAM_WIDTH = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_LEVEL  = DEPTH - 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [STREAM_WIDTH-1:0]       inbound_data_i,
    input  logic                          inbound_valid_i,
    output logic                          inbound_ready_o,
    output logic [STREAM_WIDTH-1:0]       outbound_data_o,
    output logic                          outbound_valid_o,
    input  logic                          outbound_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]    level_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          almost_full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
        $fatal(1, "nx_stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if (!afull_legal(AFULL_LEVEL, DEPTH)) begin : g_bad_afull
        $fatal(1, "nx_stream_fifo: AFULL_LEVEL must lie in 1..DEPTH");
    end

    // Pointers carry one extra MSB as a wrap flag so full and empty differ.
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           occupancy;
    logic [STREAM_WIDTH-1:0] mem_q [DEPTH];
    logic                    push;
    logic                    pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Modulo-2*DEPTH difference gives the occupancy directly, including DEPTH.
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign level_o       = LW'(occupancy);
    assign almost_full_o = (level_o >= LW'(AFULL_LEVEL));

    assign inbound_ready_o  = !full_o;
    assign outbound_valid_o = !empty_o;
    assign outbound_data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push = inbound_valid_i && inbound_ready_o;
    assign pop  = outbound_valid_o && outbound_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            // Flush wins over any handshake in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= inbound_data_i;
        end
    end

endmodule

// File: tb/tb_nx_stream_fifo.sv
// tb_nx_stream_fifo: directed and randomized bench for nx_stream_fifo against a
// queue-based reference model.
module tb_nx_stream_fifo;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned AF = D - 1;
    localparam int unsigned LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic [W-1:0]  inbound_data_i;
    logic          inbound_valid_i;
    logic          inbound_ready_o;
    logic [W-1:0]  outbound_data_o;
    logic          outbound_valid_o;
    logic          outbound_ready_i;
    logic [LW-1:0] level_o;
    logic          empty_o;
    logic          full_o;
    logic          almost_full_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] model_q[$];

    nx_stream_fifo #(
        .STREAM_WIDTH (W),
        .DEPTH        (D),
        .AFULL_LEVEL  (AF)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .inbound_data_i   (inbound_data_i),
        .inbound_valid_i  (inbound_valid_i),
        .inbound_ready_o  (inbound_ready_o),
        .outbound_data_o  (outbound_data_o),
        .outbound_valid_o (outbound_valid_o),
        .outbound_ready_i (outbound_ready_i),
        .level_o          (level_o),
        .empty_o          (empty_o),
        .full_o           (full_o),
        .almost_full_o    (almost_full_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs follow from the model's occupancy and head entry alone.
    task automatic check_model();
        int n;
        n = model_q.size();
        check("level",  64'(level_o),          64'(n));
        check("empty",  64'(empty_o),          64'(n == 0));
        check("full",   64'(full_o),           64'(n == int'(D)));
        check("afull",  64'(almost_full_o),    64'(n >= int'(AF)));
        check("iready", 64'(inbound_ready_o),  64'(n != int'(D)));
        check("ovalid", 64'(outbound_valid_o), 64'(n != 0));
        if (n > 0) begin
            check("odata", 64'(outbound_data_o), 64'(model_q[0]));
        end
    endtask

    // Apply one cycle of stimulus, update the model at the edge, check at the negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        bit do_push;
        bit do_pop;
        inbound_valid_i  = v;
        inbound_data_i   = d;
        outbound_ready_i = r;
        flush_i          = f;
        do_push = v && (model_q.size() < int'(D));
        do_pop  = r && (model_q.size() > 0);
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"},  64'(level_o),          64'(0));
        check({tag, "_empty"},  64'(empty_o),          64'(1));
        check({tag, "_full"},   64'(full_o),           64'(0));
        check({tag, "_afull"},  64'(almost_full_o),    64'(0));
        check({tag, "_iready"}, 64'(inbound_ready_o),  64'(1));
        check({tag, "_ovalid"}, 64'(outbound_valid_o), 64'(0));
    endtask

    initial begin
        logic [W-1:0] seq [4];
        logic [W-1:0] tail [4];
        int bias;

        rst_i = 1'b1;
        flush_i = 1'b0;
        inbound_valid_i = 1'b0;
        inbound_data_i = '0;
        outbound_ready_i = 1'b0;
        #1;
        check_reset_values("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check_model();

        // Single word into empty appears one cycle later.
        step(1'b1, 32'h11, 1'b0, 1'b0);
        check("lat_valid", 64'(outbound_valid_o), 64'(1));
        check("lat_data",  64'(outbound_data_o),  64'h11);
        check("lat_level", 64'(level_o),          64'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        check("lat_drained", 64'(empty_o), 64'(1));

        // Fill to full without popping, then drain in order.
        seq[0] = 32'hA000_0001;
        seq[1] = 32'hB000_0002;
        seq[2] = 32'hC000_0003;
        seq[3] = 32'hD000_0004;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b0);
            if (i == 2) begin
                check("fill_afull3", 64'(almost_full_o), 64'(1));
                check("fill_full3",  64'(full_o),        64'(0));
            end
        end
        check("fill_full",   64'(full_o),          64'(1));
        check("fill_level",  64'(level_o),         64'(4));
        check("fill_iready", 64'(inbound_ready_o), 64'(0));
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 64'(outbound_data_o), 64'(seq[i]));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", 64'(empty_o), 64'(1));

        // Steady level 2 with simultaneous push and pop; pointers wrap.
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h101, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h200 + W'(i), 1'b1, 1'b0);
            check("steady_level", 64'(level_o), 64'(2));
        end
        check("steady_head", 64'(outbound_data_o), 64'h208);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Full with a blocked push of 0xEE alongside a pop, then retry.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1 + W'(i), 1'b0, 1'b0);
        step(1'b1, 32'hEE, 1'b1, 1'b0);
        check("blocked_level", 64'(level_o), 64'(3));
        step(1'b1, 32'hEE, 1'b0, 1'b0);
        check("retry_level", 64'(level_o), 64'(4));
        tail[0] = 32'h2;
        tail[1] = 32'h3;
        tail[2] = 32'h4;
        tail[3] = 32'hEE;
        for (int i = 0; i < 4; i++) begin
            check("retry_order", 64'(outbound_data_o), 64'(tail[i]));
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Flush at level 3 overriding push and pop.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + W'(i), 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b1, 1'b1);
        check("flush_level",  64'(level_o),          64'(0));
        check("flush_empty",  64'(empty_o),          64'(1));
        check("flush_ovalid", 64'(outbound_valid_o), 64'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h66, 1'b1, 1'b0);
        check("postflush_data", 64'(outbound_data_o), 64'h66);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst.
        step(1'b1, 32'h71, 1'b0, 1'b0);
        step(1'b1, 32'h72, 1'b0, 1'b0);
        inbound_valid_i = 1'b1;
        inbound_data_i  = 32'h73;
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_values("rst_async");
        model_q.delete();
        @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        @(negedge clk);
        rst_i = 1'b0;
        inbound_valid_i = 1'b0;
        step(1'b1, 32'h81, 1'b0, 1'b0);
        step(1'b1, 32'h82, 1'b0, 1'b0);
        check("postrst_data", 64'(outbound_data_o), 64'h81);
        step(1'b0, '0, 1'b1, 1'b0);
        check("postrst_data2", 64'(outbound_data_o), 64'h82);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 3000; i++) begin
            bias = (i / 200) % 3;
            step((bias == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1),
                 W'($urandom),
                 (bias == 2) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
